uart_rx_pkt_ctrl: RTL and testbench

- Read-side controller for the UART RX byte FIFO.
- Drains the FIFO with a read-strobe/empty handshake and frames the byte stream into packets: SYNC, LEN, LEN payload bytes, then a CSUM byte.
- Streams payload bytes downstream under valid/ready backpressure.
- Reports end-of-packet status as a good pulse or an error pulse with a code.
- Sits between the RX FIFO and the command/register layer.

---
 rtl/uart_pkt_pkg.sv | 23 ++
 rtl/uart_fifo_reader.sv | 35 +++
 rtl/uart_rx_pkt_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkt_pkg
// Brief    : Shared state encodings, error codes and defaults for the UART RX
//            packet controller.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkt_pkg;

  localparam logic [2:0] S_HUNT = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : uart_fifo_reader
// Brief    : FETCH/LATCH handshake on the RX FIFO; turns read strobes into a
//            byte stream with a one-cycle valid, throttled by i_Hold.
// Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_reader (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Fifo_Empty,
  input  logic [7:0] i_Fifo_Data,
  input  logic       i_Hold,
  output logic       o_Fifo_Rd,
  output logic       o_Byte_Valid,
  output logic [7:0] o_Byte
);

  logic r_latch;

  // r_latch marks the LATCH cycle, which also blocks back-to-back strobes.
  assign o_Fifo_Rd    = !i_Reset && !i_Fifo_Empty && !i_Hold && !r_latch;
  assign o_Byte_Valid = r_latch;
  assign o_Byte       = i_Fifo_Data;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_latch <= 1'b0;
    end else begin
      r_latch <= o_Fifo_Rd;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_pkt_ctrl
// Brief    : Frames the RX FIFO byte stream into SYNC/LEN/payload/CSUM packets
//            and streams payload under valid/ready. Optional inter-byte idle
//            timeout is enabled by defining UART_RX_PKT_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_pkt_ctrl
  import uart_pkt_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Fifo_Empty,
  input  logic [7:0] i_Fifo_Data,
  output logic       o_Fifo_Rd,
  output logic [7:0] o_Data,
  output logic       o_Data_Valid,
  input  logic       i_Data_Ready,
  output logic       o_Data_First,
  output logic       o_Data_Last,
  output logic       o_Pkt_Done,
  output logic       o_Pkt_Err,
  output logic [1:0] o_Err_Code,
  output logic [2:0] o_State
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0] r_state;
  logic [7:0] r_csum;
  logic [7:0] r_count;
  logic       r_first_pending;
  logic [7:0] r_data;
  logic       r_data_valid;
  logic       r_data_first;
  logic       r_data_last;
  logic       r_pkt_done;
  logic       r_pkt_err;
  logic [1:0] r_err_code;

  logic       w_hold;
  logic       w_byte_vld;
  logic [7:0] w_byte;
  logic       w_xfer;
  logic       w_tmo;

  // Any pending output blocks the next fetch, so status pulses never overlap
  // the read of the following packet's SYNC.
  assign w_hold = r_data_valid || r_pkt_done || r_pkt_err;
  assign w_xfer = r_data_valid && i_Data_Ready;

  uart_fifo_reader u_reader (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Fifo_Empty (i_Fifo_Empty),
    .i_Fifo_Data  (i_Fifo_Data),
    .i_Hold       (w_hold),
    .o_Fifo_Rd    (o_Fifo_Rd),
    .o_Byte_Valid (w_byte_vld),
    .o_Byte       (w_byte)
  );

`ifdef UART_RX_PKT_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_idle;
  logic        w_waiting;

  // Only starvation counts; a stalled output byte keeps w_waiting low.
  assign w_waiting = (r_state != S_HUNT) && i_Fifo_Empty && !w_byte_vld && !r_data_valid;
  assign w_tmo     = w_waiting && (r_idle == TMO_LAST);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_idle <= 16'd0;
    end else if (o_Fifo_Rd || (r_state == S_HUNT) || w_tmo) begin
      r_idle <= 16'd0;
    end else if (w_waiting) begin
      r_idle <= r_idle + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign w_tmo          = 1'b0;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state         <= S_HUNT;
      r_csum          <= 8'd0;
      r_count         <= 8'd0;
      r_first_pending <= 1'b0;
      r_data          <= 8'd0;
      r_data_valid    <= 1'b0;
      r_data_first    <= 1'b0;
      r_data_last     <= 1'b0;
      r_pkt_done      <= 1'b0;
      r_pkt_err       <= 1'b0;
      r_err_code      <= ERR_NONE;
    end else begin
      r_pkt_done <= 1'b0;
      r_pkt_err  <= 1'b0;

      if (w_xfer) begin
        r_data_valid <= 1'b0;
        r_data_first <= 1'b0;
        r_data_last  <= 1'b0;
        r_count      <= r_count - 8'd1;
        if (r_count == 8'd1) begin
          r_state <= S_CSUM;
        end
      end

      if (w_byte_vld) begin
        case (r_state)
          S_HUNT: begin
            if (w_byte == SYNC_BYTE) begin
              r_csum  <= 8'd0;
              r_state <= S_LEN;
            end
          end
          S_LEN: begin
            if ((w_byte == 8'd0) || (w_byte > MAX_LEN_B)) begin
              r_pkt_err  <= 1'b1;
              r_err_code <= ERR_LEN;
              r_state    <= S_HUNT;
            end else begin
              r_csum          <= w_byte;
              r_count         <= w_byte;
              r_first_pending <= 1'b1;
              r_state         <= S_DATA;
            end
          end
          S_DATA: begin
            r_csum          <= r_csum ^ w_byte;
            r_data          <= w_byte;
            r_data_valid    <= 1'b1;
            r_data_first    <= r_first_pending;
            r_data_last     <= (r_count == 8'd1);
            r_first_pending <= 1'b0;
          end
          S_CSUM: begin
            if (w_byte == r_csum) begin
              r_pkt_done <= 1'b1;
            end else begin
              r_pkt_err  <= 1'b1;
              r_err_code <= ERR_CSUM;
            end
            r_state <= S_HUNT;
          end
          default: r_state <= S_HUNT;
        endcase
      end

      if (w_tmo) begin
        r_pkt_err  <= 1'b1;
        r_err_code <= ERR_TMO;
        r_state    <= S_HUNT;
      end
    end
  end

  assign o_Data       = r_data;
  assign o_Data_Valid = r_data_valid;
  assign o_Data_First = r_data_first;
  assign o_Data_Last  = r_data_last;
  assign o_Pkt_Done   = r_pkt_done;
  assign o_Pkt_Err    = r_pkt_err;
  assign o_Err_Code   = r_err_code;
  assign o_State      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_pkt_ctrl
// Brief    : Scoreboard bench for uart_rx_pkt_ctrl with a queue-backed FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_pkt_ctrl;

  typedef struct packed {
    logic [1:0] kind;   // 0 data, 1 done, 2 err
    logic [7:0] data;
    logic       first;
    logic       last;
    logic [1:0] code;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       data_ready = 1'b1;
  logic       fifo_rd, data_valid, data_first, data_last, pkt_done, pkt_err;
  logic [7:0] data;
  logic [1:0] err_code;
  logic [2:0] state;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] fifo_q[$];
  logic [7:0] pkt[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_viol   = 0;
  logic       rd_prev  = 1'b0;

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE      (8'hA5),
    .MAX_LEN        (16),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .i_Clock      (clk),
    .i_Reset      (rst),
    .i_Fifo_Empty (fifo_empty),
    .i_Fifo_Data  (fifo_data),
    .o_Fifo_Rd    (fifo_rd),
    .o_Data       (data),
    .o_Data_Valid (data_valid),
    .i_Data_Ready (data_ready),
    .o_Data_First (data_first),
    .o_Data_Last  (data_last),
    .o_Pkt_Done   (pkt_done),
    .o_Pkt_Err    (pkt_err),
    .o_Err_Code   (err_code),
    .o_State      (state)
  );

  // FIFO model: pop on strobe, read data valid the following cycle.
  always @(posedge clk) begin
    if (fifo_rd && fifo_empty) n_viol++;
    if (fifo_rd && rd_prev)    n_viol++;
    rd_prev <= fifo_rd;
    if (fifo_rd && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
  end

  always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);

  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid && data_ready) obs_q.push_back({2'd0, data, data_first, data_last, 2'b00});
      if (pkt_done) obs_q.push_back({2'd1, 8'h00, 1'b0, 1'b0, 2'b00});
      if (pkt_err)  obs_q.push_back({2'd2, 8'h00, 1'b0, 1'b0, err_code});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference framing model: produces expected events for a byte stream.
  task automatic model(input logic [7:0] b[$]);
    int         st = 0;
    int         cnt = 0;
    logic [7:0] cs = 8'h00;
    logic       first = 1'b0;
    foreach (b[i]) begin
      case (st)
        0: if (b[i] == 8'hA5) st = 1;
        1: begin
          if (b[i] == 8'h00 || b[i] > 8'd16) begin
            exp_q.push_back({2'd2, 8'h00, 1'b0, 1'b0, 2'b01});
            st = 0;
          end else begin
            cs = b[i]; cnt = int'(b[i]); first = 1'b1; st = 2;
          end
        end
        2: begin
          cs = cs ^ b[i];
          exp_q.push_back({2'd0, b[i], first, (cnt == 1), 2'b00});
          first = 1'b0;
          cnt--;
          if (cnt == 0) st = 3;
        end
        default: begin
          if (b[i] == cs) exp_q.push_back({2'd1, 8'h00, 1'b0, 1'b0, 2'b00});
          else            exp_q.push_back({2'd2, 8'h00, 1'b0, 1'b0, 2'b10});
          st = 0;
        end
      endcase
    end
  endtask

  task automatic send(input logic [7:0] b[$]);
    model(b);
    foreach (b[i]) fifo_q.push_back(b[i]);
  endtask

  task automatic wait_events(output bit ok);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 600) begin
      tick();
      n++;
    end
    ok = (obs_q.size() >= exp_q.size());
    repeat (6) tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if ({fifo_rd, data, data_valid, data_first, data_last, pkt_done, pkt_err, err_code, state} !== 21'd0)
      $display("FAIL reset_outputs: got rd=%b d=%h v=%b f=%b l=%b done=%b err=%b code=%b st=%0d want all 0",
               fifo_rd, data, data_valid, data_first, data_last, pkt_done, pkt_err, err_code, state);
    else n_pass++;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    bit ok; ev_t e, o;
    pkt = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    send(pkt);
    wait_events(ok);
    if (!ok) begin n_checks++; $display("FAIL basic_wait: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL basic_event: got %h want %h", o, e); else n_pass++;
    end
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL basic_extra: got %0d extra events want 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_junk();
    bit ok; ev_t e, o;
    pkt = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hAA, 8'h55, 8'hFD};
    send(pkt);
    wait_events(ok);
    if (!ok) begin n_checks++; $display("FAIL junk_wait: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL junk_event: got %h want %h", o, e); else n_pass++;
    end
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL junk_extra: got %0d extra events want 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_bad_csum();
    bit ok; ev_t e, o;
    pkt = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send(pkt);
    wait_events(ok);
    if (!ok) begin n_checks++; $display("FAIL csum_wait: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL csum_event: got %h want %h", o, e); else n_pass++;
    end
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL csum_extra: got %0d extra events want 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_bad_len();
    bit ok; ev_t e, o;
    pkt = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h10};
    pkt = pkt[0:3];
    send(pkt);
    wait_events(ok);
    if (!ok) begin n_checks++; $display("FAIL len_wait: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL len_event: got %h want %h", o, e); else n_pass++;
    end
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL len_extra: got %0d extra events want 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_stall();
    bit ok; ev_t e, o;
    int n = 0;
    int bad = 0;
    logic [7:0] held;
    pkt = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send(pkt);
    while (obs_q.size() < 1 && n < 200) begin tick(); n++; end
    data_ready = 1'b0;
    n = 0;
    while (!data_valid && n < 50) begin tick(); n++; end
    held = data;
    repeat (10) begin
      tick();
      if (fifo_rd !== 1'b0 || data_valid !== 1'b1 || data !== held) bad++;
    end
    n_checks++;
    if (bad != 0 || held !== 8'h02)
      $display("FAIL stall_hold: got %0d unstable cycles, byte %h want 0 unstable, byte 02", bad, held);
    else n_pass++;
    data_ready = 1'b1;
    wait_events(ok);
    if (!ok) begin n_checks++; $display("FAIL stall_wait: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL stall_event: got %h want %h", o, e); else n_pass++;
    end
    n_checks++;
    if (obs_q.size() !== 0) $display("FAIL stall_extra: got %0d extra events want 0", obs_q.size()); else n_pass++;
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    int n = 0;
    data_ready = 1'b0;
    pkt = '{8'hA5, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h50};
    send(pkt);
    while (!data_valid && n < 100) begin tick(); n++; end
    n_checks++;
    if (state !== 3'd2 || data_valid !== 1'b1)
      $display("FAIL areset_pre: got state=%0d valid=%b want state=2 valid=1", state, data_valid);
    else n_pass++;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({fifo_rd, data, data_valid, data_first, data_last, pkt_done, pkt_err, err_code, state} !== 21'd0)
      $display("FAIL areset_outputs: got d=%h v=%b f=%b l=%b done=%b err=%b code=%b st=%0d want all 0",
               data, data_valid, data_first, data_last, pkt_done, pkt_err, err_code, state);
    else n_pass++;
    fifo_q.delete();
    exp_q.delete();
    obs_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    data_ready = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (obs_q.size() !== 0 || state !== 3'd0)
      $display("FAIL areset_quiet: got %0d events state=%0d want 0 events state=0", obs_q.size(), state);
    else n_pass++;
    obs_q.delete();
  endtask

`ifdef UART_RX_PKT_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; ev_t e, o;
    pkt = '{8'hA5, 8'h04, 8'h11};
    send(pkt);
    exp_q.push_back({2'd2, 8'h00, 1'b0, 1'b0, 2'b11});
    wait_events(ok);
    if (!ok) begin n_checks++; $display("FAIL tmo_wait: got %0d events want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      n_checks++;
      if (o !== e) $display("FAIL tmo_event: got %h want %h", o, e); else n_pass++;
    end
    n_checks++;
    if (state !== 3'd0) $display("FAIL tmo_state: got %0d want 0", state); else n_pass++;
    obs_q.delete();
  endtask
`endif

  task automatic test_protocol();
    n_checks++;
    if (n_viol !== 0) $display("FAIL fifo_protocol: got %0d strobe violations want 0", n_viol);
    else n_pass++;
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_junk();
    test_bad_csum();
    test_bad_len();
    test_stall();
    test_async_reset();
`ifdef UART_RX_PKT_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
